// File: rtl/cmp_serial.sv
// Serial compare unit: evaluates B - A one slice per clock, LSB first, and
// returns a condition flag plus raw carry through a valid/ready handshake.
module cmp_serial #(
    parameter int DW    = 16,
    parameter int SLICE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          flag,
    output logic          carry,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam int N  = DW / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; the producer holds valid and its data steady until then.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [2:0]      r_op;
    logic            r_carry_acc;
    logic            r_zero_acc;
    logic [IW-1:0]   r_idx;
    logic            r_flag;
    logic            r_carry;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_sum;
    logic             w_z;
    logic             w_sgn;
    logic             w_flag;
    logic             w_last;

    // Operands are shifted right each RUN cycle, so the live slice is always bits [SLICE-1:0].
    assign w_a_sl = r_a[SLICE-1:0];
    assign w_b_sl = r_b[SLICE-1:0];
    assign w_sum  = {1'b0, w_b_sl} + {1'b0, ~w_a_sl} + {{SLICE{1'b0}}, r_carry_acc};
    assign w_z    = r_zero_acc & (w_sum[SLICE-1:0] == '0);
    assign w_sgn  = w_sum[SLICE-1];
    assign w_last = (r_idx == IW'(N - 1));

    always_comb begin
        w_flag = 1'b0;
        case (r_op)
            3'b000:  w_flag = w_z;
            3'b001:  w_flag = ~w_z;
            3'b010:  w_flag = ~w_z & ~w_sgn;
            3'b011:  w_flag = w_sgn;
            3'b100:  w_flag = ~w_sgn;
            3'b101:  w_flag = w_sgn | w_z;
            default: w_flag = w_sum[SLICE];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_carry_acc <= 1'b0;
            r_zero_acc  <= 1'b0;
            r_idx       <= '0;
            r_flag      <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_op        <= op;
                        r_carry_acc <= 1'b1;
                        r_zero_acc  <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a         <= r_a >> SLICE;
                    r_b         <= r_b >> SLICE;
                    r_carry_acc <= w_sum[SLICE];
                    r_zero_acc  <= w_z;
                    r_idx       <= r_idx + IW'(1);
                    if (w_last) begin
                        r_flag  <= w_flag;
                        r_carry <= w_sum[SLICE];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign flag      = r_flag;
    assign carry     = r_carry;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cmp_serial.sv
// Bench for cmp_serial: directed cases, backpressure, mid-run reset and
// random requests scored against an arithmetic model of B - A.
module tb_cmp_serial;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic          flag;
    logic          carry;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    cmp_serial #(.DW(DW), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flag      (flag),
        .carry     (carry),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // returns {flag, carry} for B - A computed at full width
    function automatic logic [1:0] model(input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                                         input logic [2:0] mop);
        logic [DW:0]   full;
        logic [DW-1:0] res;
        logic          cy, z, sgn, f;
        full = {1'b0, mb} + {1'b0, ~ma} + 1;
        res  = full[DW-1:0];
        cy   = full[DW];
        z    = (res == 0);
        sgn  = res[DW-1];
        case (mop)
            3'd0:    f = z;
            3'd1:    f = !z;
            3'd2:    f = !z && !sgn;
            3'd3:    f = sgn;
            3'd4:    f = !sgn;
            3'd5:    f = sgn || z;
            default: f = cy;
        endcase
        return {f, cy};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // drives one request, measures latency, holds out_ready low for 'hold' cycles
    task automatic run_req(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                           input logic [2:0] top, input int hold, input string tag);
        logic [1:0] expv;
        int lat;
        exp_q.push_back(model(ta, tb_v, top));
        out_ready = 1'b0;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        a = ta; b = tb_v; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = DW'($urandom); b = DW'($urandom); op = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        expv = exp_q.pop_front();
        check({tag, "_latency"}, lat, 4);
        check({tag, "_flag"}, flag, expv[1]);
        check({tag, "_carry"}, carry, expv[0]);
        check({tag, "_in_ready_done"}, in_ready, 0);
        check({tag, "_busy_done"}, busy, 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = DW'($urandom); b = DW'($urandom); op = 3'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_in_ready"}, in_ready, 0);
            check({tag, "_hold_flag"}, flag, expv[1]);
            check({tag, "_hold_carry"}, carry, expv[0]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_after"}, out_valid, 0);
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        logic [DW-1:0] ra, rb;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_flag", flag, 0);
        check("rst_carry", carry, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req(16'd5, 16'd5, 3'b000, 0, "eq_5_5");
        check("eq_5_5_model", model(16'd5, 16'd5, 3'b000), 2'b11);
        run_req(16'd3, 16'd7, 3'b010, 0, "lt_3_7");
        run_req(16'd3, 16'd7, 3'b011, 0, "gt_3_7");
        run_req(16'd7, 16'd3, 3'b011, 0, "gt_7_3");
        run_req(16'd7, 16'd3, 3'b100, 0, "le_7_3");
        run_req(16'd7, 16'd3, 3'b101, 0, "ge_7_3");
        run_req(16'd0, 16'd0, 3'b110, 0, "cry_0_0");
        run_req(16'd1, 16'd0, 3'b111, 0, "cry_1_0");
        run_req(16'hFFFF, 16'h0000, 3'b001, 0, "neq_edge");
        run_req(16'h1234, 16'h1234, 3'b101, 0, "ge_equal");

        // backpressure with a competing request held on the input
        run_req(16'h0010, 16'h8000, 3'b011, 10, "backpressure");

        // reset while RUN has processed two slices
        a = 16'd9; b = 16'd2; op = 3'b011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_result", out_valid, 0);
        end
        run_req(16'd9, 16'd2, 3'b011, 0, "after_rst");

        // random requests, biased toward equal operands now and then
        for (int i = 0; i < 40; i++) begin
            ra = DW'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : DW'($urandom);
            run_req(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 2), "rand");
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
